cpx_multiply_axis: RTL and testbench

Fully handshaked, parametrised complex multiplier for the CAF datapath. It computes x·y or x·conj(y) per beat, then applies a parametrised right shift, optional round-half-up and saturation to the output width. Every pipeline stage tracks its own valid bit, so bubbles collapse and backpressure stalls only the stages that need to stall. It sits between the reference/signal sample streams and the downstream accumulate/FFT stages, and carries tlast alongside the data.

---
 rtl/cpx_multiply_axis.sv | 125 ++++++++++++
 tb/tb_cpx_multiply_axis.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/cpx_multiply_axis.sv
// cpx_multiply_axis: four-stage handshaked complex multiplier (x*y or x*conj(y)) with shift, round and saturate
module cpx_multiply_axis #(
   parameter int x_bits = 12,
   parameter int y_bits = 12,
   parameter int out_bits = 16,
   parameter int shift = x_bits + y_bits - out_bits,
   parameter bit round_en = 1'b1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       s_axis_tvalid,
   output logic                       s_axis_tready,
   input  logic                       s_axis_tlast,
   input  logic                       s_axis_tuser,
   input  logic signed [x_bits-1:0]   xi,
   input  logic signed [x_bits-1:0]   xq,
   input  logic signed [y_bits-1:0]   yi,
   input  logic signed [y_bits-1:0]   yq,
   output logic                       m_axis_tvalid,
   input  logic                       m_axis_tready,
   output logic                       m_axis_tlast,
   output logic signed [out_bits-1:0] i,
   output logic signed [out_bits-1:0] q,
   output logic                       ovf,
   input  logic                       ovf_clr
);
   localparam int M = x_bits + y_bits;
   localparam int P = M + 1;
   localparam int W = (P > out_bits ? P : out_bits) + 1;
   localparam logic signed [W-1:0] RND = W'(round_en && shift > 0) << (shift > 0 ? shift - 1 : 0);
   localparam logic signed [W-1:0] MAXV = {{(W-out_bits+1){1'b0}}, {(out_bits-1){1'b1}}};
   localparam logic signed [W-1:0] MINV = ~MAXV;

   logic v1_q, v2_q, v3_q;
   logic en1, en2, en3, en4;
   logic signed [x_bits-1:0] xi_q, xq_q;
   logic signed [y_bits-1:0] yi_q, yq_q;
   logic l1_q, c1_q, l2_q, c2_q, l3_q;
   logic signed [M-1:0] xu_q, yv_q, xv_q, yu_q;
   logic signed [P-1:0] si_q, sq_q;
   logic signed [out_bits-1:0] i_d, q_d;
   logic sat_i, sat_q, ovf_d;

   // Grow one bit past the sum so the rounding constant can never wrap
   function automatic logic [out_bits:0] scale(input logic signed [P-1:0] v);
      logic signed [W-1:0] r;
      r = {{(W-P){v[P-1]}}, v};
      r = r + RND;
      r = r >>> shift;
      return r > MAXV ? {1'b1, MAXV[out_bits-1:0]} :
             r < MINV ? {1'b1, MINV[out_bits-1:0]} : {1'b0, r[out_bits-1:0]};
   endfunction

   assign en4 = ~m_axis_tvalid | m_axis_tready;
   assign en3 = ~v3_q | en4;
   assign en2 = ~v2_q | en3;
   assign en1 = ~v1_q | en2;
   assign s_axis_tready = en1;

   always_comb begin
      {sat_i, i_d} = scale(si_q);
      {sat_q, q_d} = scale(sq_q);
      ovf_d = (en4 & v3_q & (sat_i | sat_q)) | (ovf & ~ovf_clr);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1_q <= 1'b0;
         v2_q <= 1'b0;
         v3_q <= 1'b0;
         m_axis_tvalid <= 1'b0;
         xi_q <= '0;
         xq_q <= '0;
         yi_q <= '0;
         yq_q <= '0;
         l1_q <= 1'b0;
         c1_q <= 1'b0;
         xu_q <= '0;
         yv_q <= '0;
         xv_q <= '0;
         yu_q <= '0;
         l2_q <= 1'b0;
         c2_q <= 1'b0;
         si_q <= '0;
         sq_q <= '0;
         l3_q <= 1'b0;
         i <= '0;
         q <= '0;
         m_axis_tlast <= 1'b0;
         ovf <= 1'b0;
      end else begin
         if (en1) begin
            v1_q <= s_axis_tvalid;
            xi_q <= xi;
            xq_q <= xq;
            yi_q <= yi;
            yq_q <= yq;
            l1_q <= s_axis_tlast;
            c1_q <= s_axis_tuser;
         end
         if (en2) begin
            v2_q <= v1_q;
            xu_q <= xi_q * yi_q;
            yv_q <= xq_q * yq_q;
            xv_q <= xi_q * yq_q;
            yu_q <= xq_q * yi_q;
            l2_q <= l1_q;
            c2_q <= c1_q;
         end
         if (en3) begin
            v3_q <= v2_q;
            si_q <= c2_q ? xu_q + yv_q : xu_q - yv_q;
            sq_q <= c2_q ? yu_q - xv_q : xv_q + yu_q;
            l3_q <= l2_q;
         end
         if (en4) begin
            m_axis_tvalid <= v3_q;
            i <= i_d;
            q <= q_d;
            m_axis_tlast <= l3_q;
         end
         ovf <= ovf_d;
      end
   end
endmodule

// File: tb/tb_cpx_multiply_axis.sv
// tb_cpx_multiply_axis: scoreboard bench for cpx_multiply_axis with rounding and truncating instances
module tb_cpx_multiply_axis;
   logic clk = 1'b0;
   logic rst, s_valid, s_last, s_user, m_ready, ovf_clr;
   logic signed [11:0] s_xi, s_xq, s_yi, s_yq;
   logic s_ready, m_valid, m_last, ovf;
   logic signed [15:0] o_i, o_q;
   logic s_ready1, m_valid1, m_last1, ovf1;
   logic signed [15:0] o_i1, o_q1;

   typedef struct {
      logic signed [15:0] i0, q0, i1, q1;
      logic last;
   } beat_t;

   beat_t sb[$];
   int errors = 0, checks = 0, outs = 0;
   bit acc;
   logic signed [15:0] last_i0, last_q0, last_i1;

   always #5 clk = ~clk;

   cpx_multiply_axis dut (
      .clk(clk), .rst(rst), .s_axis_tvalid(s_valid), .s_axis_tready(s_ready),
      .s_axis_tlast(s_last), .s_axis_tuser(s_user), .xi(s_xi), .xq(s_xq), .yi(s_yi), .yq(s_yq),
      .m_axis_tvalid(m_valid), .m_axis_tready(m_ready), .m_axis_tlast(m_last),
      .i(o_i), .q(o_q), .ovf(ovf), .ovf_clr(ovf_clr)
   );

   cpx_multiply_axis #(.round_en(1'b0)) dut_trunc (
      .clk(clk), .rst(rst), .s_axis_tvalid(s_valid), .s_axis_tready(s_ready1),
      .s_axis_tlast(s_last), .s_axis_tuser(s_user), .xi(s_xi), .xq(s_xq), .yi(s_yi), .yq(s_yq),
      .m_axis_tvalid(m_valid1), .m_axis_tready(m_ready), .m_axis_tlast(m_last1),
      .i(o_i1), .q(o_q1), .ovf(ovf1), .ovf_clr(ovf_clr)
   );

   task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic signed [15:0] scl(input longint v, input bit rnd);
      longint r;
      r = (rnd ? v + 128 : v) >>> 8;
      return 16'(r > 32767 ? 32767 : r < -32768 ? -32768 : r);
   endfunction

   function automatic beat_t model(input longint a, b, c, d, input logic cj, lst);
      longint vi, vq;
      beat_t e;
      vi = cj ? a * c + b * d : a * c - b * d;
      vq = cj ? b * c - a * d : a * d + b * c;
      e.i0 = scl(vi, 1'b1);
      e.q0 = scl(vq, 1'b1);
      e.i1 = scl(vi, 1'b0);
      e.q1 = scl(vq, 1'b0);
      e.last = lst;
      return e;
   endfunction

   always @(negedge clk) begin
      if (!rst) begin
         beat_t e;
         chk("tready", s_ready, !(sb.size() == 4 && !m_ready));
         if (m_valid && m_ready) begin
            outs++;
            if (sb.size() == 0) chk("unexpected_out", 1, 0);
            else begin
               e = sb.pop_front();
               chk("i", o_i, e.i0);
               chk("q", o_q, e.q0);
               chk("tlast", m_last, e.last);
               chk("i_trunc", o_i1, e.i1);
               chk("q_trunc", o_q1, e.q1);
               last_i0 = o_i;
               last_q0 = o_q;
               last_i1 = o_i1;
            end
         end
         if (s_valid && s_ready) sb.push_back(model(s_xi, s_xq, s_yi, s_yq, s_user, s_last));
      end
   end

   task automatic step();
      @(negedge clk);
      #1 acc = s_valid && s_ready;
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic signed [11:0] a, b, c, d, input logic cj, lst);
      int g = 0;
      s_xi = a; s_xq = b; s_yi = c; s_yq = d; s_user = cj; s_last = lst;
      s_valid = 1'b1;
      acc = 1'b0;
      while (!acc && g < 200) begin
         step();
         g++;
      end
      if (!acc) chk("send_timeout", 0, 1);
      s_valid = 1'b0;
   endtask

   task automatic drain();
      int g = 0;
      m_ready = 1'b1;
      while (sb.size() != 0 && g < 50) begin
         @(posedge clk);
         #1 g++;
      end
      chk("drain", sb.size(), 0);
   endtask

   initial begin
      #200000 $display("FAIL watchdog: bench did not finish");
      $fatal(1);
   end

   initial begin
      int lat, sent, g, o0;
      rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_user = 1'b0; m_ready = 1'b1; ovf_clr = 1'b0;
      s_xi = '0; s_xq = '0; s_yi = '0; s_yq = '0;
      #12;
      chk("rst_tready", s_ready, 1);
      chk("rst_tvalid", m_valid, 0);
      chk("rst_tlast", m_last, 0);
      chk("rst_i", o_i, 0);
      chk("rst_q", o_q, 0);
      chk("rst_ovf", ovf, 0);
      @(posedge clk);
      #3 rst = 1'b0;
      @(posedge clk);
      #1;
      send(256, 256, 256, 256, 1'b0, 1'b0);
      lat = 1;
      while (!m_valid && lat < 20) begin
         @(posedge clk);
         #1 lat++;
      end
      chk("latency", lat, 4);
      drain();
      chk("basic_i", last_i0, 0);
      chk("basic_q", last_q0, 512);
      send(256, 256, 256, 256, 1'b1, 1'b0);
      drain();
      chk("conj_i", last_i0, 512);
      chk("conj_q", last_q0, 0);
      chk("ovf_clean", ovf, 0);
      send(-2048, -2048, -2048, -2048, 1'b1, 1'b1);
      drain();
      chk("sat_i", last_i0, 32767);
      chk("sat_q", last_q0, 0);
      chk("ovf_set", ovf, 1);
      repeat (5) @(posedge clk);
      #1 chk("ovf_sticky", ovf, 1);
      ovf_clr = 1'b1;
      @(posedge clk);
      #1 ovf_clr = 1'b0;
      chk("ovf_clr", ovf, 0);
      send(1, 0, 128, 0, 1'b0, 1'b0);
      drain();
      chk("rnd_up", last_i0, 1);
      chk("trunc_up", last_i1, 0);
      send(1, 0, -128, 0, 1'b0, 1'b0);
      drain();
      chk("rnd_dn", last_i0, 0);
      chk("trunc_dn", last_i1, -1);
      sent = 0;
      g = 0;
      s_xi = 12'($urandom); s_xq = 12'($urandom); s_yi = 12'($urandom); s_yq = 12'($urandom);
      s_user = 1'($urandom); s_last = 1'b0;
      while (sent < 32 && g < 2000) begin
         m_ready = 1'($urandom_range(0, 1));
         if (!s_valid) s_valid = 1'($urandom_range(0, 1));
         step();
         g++;
         if (acc) begin
            sent++;
            s_valid = 1'b0;
            s_xi = 12'($urandom); s_xq = 12'($urandom); s_yi = 12'($urandom); s_yq = 12'($urandom);
            s_user = 1'($urandom); s_last = (sent % 8 == 7);
         end
      end
      chk("random_sent", sent, 32);
      s_valid = 1'b0;
      drain();
      m_ready = 1'b0;
      send(100, -200, 300, -400, 1'b0, 1'b0);
      send(5, 6, 7, 8, 1'b1, 1'b0);
      send(-9, 10, -11, 12, 1'b0, 1'b1);
      @(posedge clk);
      #1 chk("pre_rst_tvalid", m_valid, 1);
      #2 rst = 1'b1;
      sb.delete();
      #1;
      chk("mid_rst_tvalid", m_valid, 0);
      chk("mid_rst_i", o_i, 0);
      chk("mid_rst_q", o_q, 0);
      @(posedge clk);
      @(posedge clk);
      #3 rst = 1'b0;
      m_ready = 1'b1;
      @(posedge clk);
      #1 o0 = outs;
      send(256, 256, 256, 256, 1'b1, 1'b1);
      drain();
      chk("post_rst_count", outs - o0, 1);
      chk("post_rst_i", last_i0, 512);
      chk("post_rst_q", last_q0, 0);
      repeat (3) @(posedge clk);
      #1 chk("post_rst_idle", m_valid, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
